// File: rtl/regfile_mp.sv
// regfile_mp: 16-index register file with banked stack pointer (index 13),
// two write ports, NRD combinational read ports and a block-transfer
// sequencer that streams registers out (store) or in (load) by mask.
//
// Physical storage is a 16-entry array. Logical index 13 maps to
// physical slot 13 (MSP) or slot 15 (PSP) depending on sp_sel. Logical
// index 15 is hard-wired to zero, so physical slot 15 is free to hold PSP.
module regfile_mp #(
    parameter int          DATA_W   = 32,
    parameter int          NRD      = 2,
    parameter int          BYPASS   = 1,
    parameter logic [31:0] SP_RESET = 32'h00001000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*4-1:0]      rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wa_en,
    input  logic [3:0]            wa_addr,
    input  logic [DATA_W-1:0]     wa_data,
    input  logic                  wb_en,
    input  logic [3:0]            wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  sp_sel,
    input  logic                  blk_start,
    input  logic [15:0]           blk_list,
    input  logic                  blk_dir,
    output logic                  blk_out_valid,
    output logic [DATA_W-1:0]     blk_out_data,
    input  logic                  blk_out_ready,
    input  logic                  blk_in_valid,
    input  logic [DATA_W-1:0]     blk_in_data,
    output logic                  blk_in_ready,
    output logic [3:0]            blk_idx,
    output logic                  blk_busy,
    output logic                  blk_done
);

    localparam logic [3:0] IDX_SP   = 4'd13;
    localparam logic [3:0] IDX_ZERO = 4'd15;
    localparam logic [3:0] PHYS_MSP = 4'd13;
    localparam logic [3:0] PHYS_PSP = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [15:0]        mask_reg, mask_next;
    logic               dir_reg, dir_next;

    logic [DATA_W-1:0]  regs_reg [0:15];
    logic [15:0]        wr_en;
    logic [DATA_W-1:0]  wr_data [0:15];

    logic [3:0]         cur_idx;
    logic [3:0]         cur_phys;
    logic               run;
    logic               seq_we;
    logic               beat_done;
    logic [DATA_W-1:0]  cur_val;

    // Map a logical index to its physical slot; index 13 follows sp_sel.
    function automatic logic [3:0] phys_of(input logic [3:0] a, input logic sel);
        if (a == IDX_SP) begin
            return sel ? PHYS_PSP : PHYS_MSP;
        end
        return a;
    endfunction

    // Current beat index: lowest set bit of the remaining mask.
    always_comb begin
        cur_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_reg[i]) begin
                cur_idx = 4'(i);
            end
        end
    end

    assign run       = (state_reg == S_RUN);
    assign seq_we    = run && dir_reg && blk_in_valid;
    assign beat_done = run && (dir_reg ? blk_in_valid : blk_out_ready);
    assign cur_phys  = phys_of(cur_idx, sp_sel);

    // Per-slot write resolution: sequencer load beats port B beats port A.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            logic seq_hit;
            logic wb_hit;
            logic wa_hit;
            seq_hit = seq_we && (cur_phys == 4'(i));
            wb_hit  = wb_en && (wb_addr != IDX_ZERO) && (phys_of(wb_addr, sp_sel) == 4'(i));
            wa_hit  = wa_en && (wa_addr != IDX_ZERO) && (phys_of(wa_addr, sp_sel) == 4'(i));
            wr_en[i] = seq_hit || wb_hit || wa_hit;
            if (seq_hit) begin
                wr_data[i] = blk_in_data;
            end else if (wb_hit) begin
                wr_data[i] = wb_data;
            end else begin
                wr_data[i] = wa_data;
            end
        end
    end

    // Register storage; both SP banks come out of reset at SP_RESET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                if (4'(i) == PHYS_MSP || 4'(i) == PHYS_PSP) begin
                    regs_reg[i] <= DATA_W'(SP_RESET);
                end else begin
                    regs_reg[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_en[i]) begin
                    regs_reg[i] <= wr_data[i];
                end
            end
        end
    end

    // Combinational read ports with optional same-cycle write forwarding.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [3:0] ra;
            logic [3:0] rp;
            assign ra = rd_addr[4*gi +: 4];
            assign rp = phys_of(ra, sp_sel);
            assign rd_data[DATA_W*gi +: DATA_W] =
                (ra == IDX_ZERO)            ? '0 :
                ((BYPASS != 0) && wr_en[rp]) ? wr_data[rp] :
                                              regs_reg[rp];
        end
    endgenerate

    // Value of the register under the current beat, forwarded like a read.
    assign cur_val = ((BYPASS != 0) && wr_en[cur_phys]) ? wr_data[cur_phys]
                                                        : regs_reg[cur_phys];

    // Sequencer state, latched mask and direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            mask_reg  <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            dir_reg   <= dir_next;
        end
    end

    // Sequencer next state: latch on start, retire one mask bit per beat.
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        dir_next   = dir_reg;
        case (state_reg)
            S_IDLE: begin
                if (blk_start) begin
                    // Bit 15 names the zero register and never takes a beat.
                    mask_next  = blk_list & 16'h7FFF;
                    dir_next   = blk_dir;
                    state_next = ((blk_list & 16'h7FFF) != 16'd0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (beat_done) begin
                    mask_next = mask_reg & ~(16'd1 << cur_idx);
                    if (mask_next == 16'd0) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign blk_out_valid = run && !dir_reg;
    assign blk_in_ready  = run && dir_reg;
    assign blk_out_data  = (run && !dir_reg) ? cur_val : '0;
    assign blk_idx       = run ? cur_idx : 4'd0;
    assign blk_busy      = (state_reg == S_RUN) || (state_reg == S_DONE);
    assign blk_done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: vector table for write-port and banking
// rules, randomized read/write traffic against an array model, and
// block-transfer sequences including a mid-transfer reset.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wa_en, wb_en;
    logic [3:0]  wa_addr, wb_addr;
    logic [31:0] wa_data, wb_data;
    logic        sp_sel;
    logic        blk_start;
    logic [15:0] blk_list;
    logic        blk_dir;
    logic        blk_out_valid;
    logic [31:0] blk_out_data;
    logic        blk_out_ready;
    logic        blk_in_valid;
    logic [31:0] blk_in_data;
    logic        blk_in_ready;
    logic [3:0]  blk_idx;
    logic        blk_busy, blk_done;

    int total = 0;
    int bad   = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sp_sel(sp_sel),
        .blk_start(blk_start), .blk_list(blk_list), .blk_dir(blk_dir),
        .blk_out_valid(blk_out_valid), .blk_out_data(blk_out_data),
        .blk_out_ready(blk_out_ready),
        .blk_in_valid(blk_in_valid), .blk_in_data(blk_in_data),
        .blk_in_ready(blk_in_ready),
        .blk_idx(blk_idx), .blk_busy(blk_busy), .blk_done(blk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: general registers and the two SP banks.
    logic [31:0] m_gp [0:14];
    logic [31:0] m_sp [0:1];

    function automatic logic [31:0] m_read(input logic [3:0] a, input logic sel);
        if (a == 4'd15) return 32'd0;
        if (a == 4'd13) return m_sp[sel];
        return m_gp[a];
    endfunction

    task automatic m_write(input logic [3:0] a, input logic sel, input logic [31:0] d);
        if (a == 4'd15) return;
        if (a == 4'd13) m_sp[sel] = d;
        else m_gp[a] = d;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 15; i++) m_gp[i] = 32'd0;
        m_sp[0] = 32'h00001000;
        m_sp[1] = 32'h00001000;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        blk_start = 0; blk_list = 0; blk_dir = 0;
        blk_out_ready = 0; blk_in_valid = 0; blk_in_data = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " out_valid"}, 32'(blk_out_valid), 32'd0);
        chk({tag, " in_ready"},  32'(blk_in_ready),  32'd0);
        chk({tag, " idx"},       32'(blk_idx),       32'd0);
        chk({tag, " busy"},      32'(blk_busy),      32'd0);
        chk({tag, " done"},      32'(blk_done),      32'd0);
        chk({tag, " out_data"},  blk_out_data,       32'd0);
    endtask

    // One block transfer. pat bit c gives the handshake in beat cycle c;
    // noise holds blk_start high with another mask during the beats.
    task automatic blk_run(input logic dir, input logic [15:0] list,
                           input logic [31:0] pat, input logic noise);
        int q[$];
        int c;
        logic hs;
        for (int b = 0; b < 15; b++) if (list[b]) q.push_back(b);
        $display("block dir=%0d list=%h beats=%0d", dir, list, q.size());
        blk_start = 1; blk_list = list; blk_dir = dir;
        @(negedge clk);
        chk("start busy", 32'(blk_busy), 32'd0);
        @(posedge clk); #1;
        blk_start = noise; blk_list = 16'h0002; blk_dir = ~dir;
        c = 0;
        while (q.size() > 0 && c < 64) begin
            hs = (c < 32) ? pat[c] : 1'b1;
            if (dir) begin
                blk_in_valid = hs; blk_in_data = $urandom;
            end else begin
                blk_out_ready = hs;
            end
            @(negedge clk);
            chk("beat busy", 32'(blk_busy), 32'd1);
            chk("beat done", 32'(blk_done), 32'd0);
            chk("beat idx", 32'(blk_idx), 32'(q[0]));
            chk("beat out_valid", 32'(blk_out_valid), 32'(!dir));
            chk("beat in_ready", 32'(blk_in_ready), 32'(dir));
            if (!dir) chk("beat out_data", blk_out_data, m_read(4'(q[0]), sp_sel));
            @(posedge clk);
            if (hs) begin
                if (dir) m_write(4'(q[0]), sp_sel, blk_in_data);
                void'(q.pop_front());
            end
            #1;
            c++;
        end
        if (q.size() > 0) chk("beat budget", 32'(q.size()), 32'd0);
        blk_start = 0; blk_in_valid = 0; blk_out_ready = 0;
        @(negedge clk);
        chk("done pulse", 32'(blk_done), 32'd1);
        chk("done busy", 32'(blk_busy), 32'd1);
        chk("done out_valid", 32'(blk_out_valid), 32'd0);
        chk("done in_ready", 32'(blk_in_ready), 32'd0);
        chk("done idx", 32'(blk_idx), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after done", 32'(blk_done), 32'd0);
        chk("after busy", 32'(blk_busy), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wa_en;
        logic [3:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        logic        sel;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] exp0, exp1;
        logic [3:0]  a0, a1;

        vecs[0]  = '{1'b1, 4'd3,  32'h11,   1'b1, 4'd3,  32'h22,   1'b0, 4'd3,  4'd15, 32'h22,   32'h0};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b0, 4'd3,  4'd13, 32'h22,   32'h1000};
        vecs[2]  = '{1'b1, 4'd13, 32'h2000, 1'b0, 4'd0,  32'h0,    1'b1, 4'd13, 4'd13, 32'h2000, 32'h2000};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b0, 4'd13, 4'd3,  32'h1000, 32'h22};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b1, 4'd13, 4'd14, 32'h2000, 32'h0};
        vecs[5]  = '{1'b1, 4'd15, 32'hDEAD, 1'b1, 4'd15, 32'hBEEF, 1'b0, 4'd15, 4'd15, 32'h0,    32'h0};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd5,  32'h55,   1'b0, 4'd5,  4'd4,  32'h55,   32'h0};
        vecs[7]  = '{1'b1, 4'd5,  32'h66,   1'b1, 4'd6,  32'h77,   1'b0, 4'd5,  4'd6,  32'h66,   32'h77};
        vecs[8]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b0, 4'd5,  4'd6,  32'h66,   32'h77};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd13, 32'h3000, 1'b0, 4'd13, 4'd3,  32'h3000, 32'h22};
        vecs[10] = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b1, 4'd13, 4'd15, 32'h2000, 32'h0};
        vecs[11] = '{1'b1, 4'd13, 32'h4444, 1'b1, 4'd13, 32'h5555, 1'b1, 4'd13, 4'd13, 32'h5555, 32'h5555};
        vecs[12] = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0,  32'h0,    1'b0, 4'd13, 4'd13, 32'h3000, 32'h3000};

        // Reset and post-reset state.
        idle_inputs();
        rst_n = 0; sp_sel = 0; rd_addr = {4'd15, 4'd13};
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk_quiet("reset");
        chk("reset r13 msp", rd_data[31:0], 32'h00001000);
        chk("reset r15", rd_data[63:32], 32'h0);
        sp_sel = 1; #1;
        chk("reset r13 psp", rd_data[31:0], 32'h00001000);
        sp_sel = 0;
        @(posedge clk); #1;

        // Vector table: same-cycle reads under write-port and bank rules.
        for (int v = 0; v < 13; v++) begin
            wa_en = vecs[v].wa_en; wa_addr = vecs[v].wa_addr; wa_data = vecs[v].wa_data;
            wb_en = vecs[v].wb_en; wb_addr = vecs[v].wb_addr; wb_data = vecs[v].wb_data;
            sp_sel = vecs[v].sel;
            rd_addr = {vecs[v].ra1, vecs[v].ra0};
            @(negedge clk);
            $display("vec %0d rd0=%h rd1=%h", v, rd_data[31:0], rd_data[63:32]);
            chk($sformatf("vec%0d rd0", v), rd_data[31:0], vecs[v].e0);
            chk($sformatf("vec%0d rd1", v), rd_data[63:32], vecs[v].e1);
            @(posedge clk); #1;
            if (vecs[v].wa_en) m_write(vecs[v].wa_addr, vecs[v].sel, vecs[v].wa_data);
            if (vecs[v].wb_en) m_write(vecs[v].wb_addr, vecs[v].sel, vecs[v].wb_data);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            wa_en = $urandom_range(0, 1); wa_addr = 4'($urandom); wa_data = $urandom;
            wb_en = $urandom_range(0, 1); wb_addr = 4'($urandom); wb_data = $urandom;
            sp_sel = $urandom_range(0, 1);
            if (n % 3 == 0) wb_addr = wa_addr;
            a0 = 4'($urandom); a1 = (n % 4 == 0) ? wb_addr : 4'($urandom);
            rd_addr = {a1, a0};
            exp0 = m_read(a0, sp_sel);
            exp1 = m_read(a1, sp_sel);
            if (wa_en && wa_addr == a0 && a0 != 4'd15) exp0 = wa_data;
            if (wb_en && wb_addr == a0 && a0 != 4'd15) exp0 = wb_data;
            if (wa_en && wa_addr == a1 && a1 != 4'd15) exp1 = wa_data;
            if (wb_en && wb_addr == a1 && a1 != 4'd15) exp1 = wb_data;
            @(negedge clk);
            chk($sformatf("rand%0d rd0 a=%0d", n, a0), rd_data[31:0], exp0);
            chk($sformatf("rand%0d rd1 a=%0d", n, a1), rd_data[63:32], exp1);
            @(posedge clk); #1;
            if (wa_en) m_write(wa_addr, sp_sel, wa_data);
            if (wb_en) m_write(wb_addr, sp_sel, wb_data);
        end
        $display("random traffic: 300 cycles");
        idle_inputs();

        // Store of r0, r2, r7 with ready 1,0,1,1.
        sp_sel = 0;
        blk_run(1'b0, 16'h0085, 32'h0000000D, 1'b0);

        // Load with only bit 15 set: straight to DONE, r15 stays zero.
        blk_run(1'b1, 16'h8000, 32'hFFFFFFFF, 1'b0);
        rd_addr = {4'd15, 4'd15};
        @(negedge clk);
        chk("r15 after load", rd_data[31:0], 32'h0);
        @(posedge clk); #1;

        // Load including PSP with gappy valid and start noise, then store all.
        sp_sel = 1;
        blk_run(1'b1, 16'h2009, 32'h0000005B, 1'b1);
        blk_run(1'b0, 16'h7FFF, $urandom, 1'b1);
        sp_sel = 0;
        blk_run(1'b0, 16'h2000, 32'h00000002, 1'b0);

        // Load r1,r2; port A hits r1 on the first beat; reset before second.
        $display("block load 0006 with reset abort");
        blk_start = 1; blk_list = 16'h0006; blk_dir = 1;
        @(posedge clk); #1;
        blk_start = 0;
        blk_in_valid = 1; blk_in_data = 32'hABCD0001;
        wa_en = 1; wa_addr = 4'd1; wa_data = 32'h99999999;
        rd_addr = {4'd2, 4'd1};
        @(negedge clk);
        chk("abort beat1 idx", 32'(blk_idx), 32'd1);
        chk("abort beat1 in_ready", 32'(blk_in_ready), 32'd1);
        chk("abort beat1 fwd r1", rd_data[31:0], 32'hABCD0001);
        @(posedge clk); #1;
        wa_en = 0;
        blk_in_data = 32'h55555555;
        @(negedge clk);
        chk("abort beat2 idx", 32'(blk_idx), 32'd2);
        chk("abort r1 holds load", rd_data[31:0], 32'hABCD0001);
        #1 rst_n = 0;
        #1;
        chk("abort busy", 32'(blk_busy), 32'd0);
        chk("abort in_ready", 32'(blk_in_ready), 32'd0);
        chk("abort idx", 32'(blk_idx), 32'd0);
        @(posedge clk); #1;
        blk_in_valid = 0;
        rst_n = 1;
        m_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort no done", 32'(blk_done), 32'd0);
            chk("abort no busy", 32'(blk_busy), 32'd0);
            chk("abort r2", rd_data[63:32], 32'h0);
            chk("abort r1 reset", rd_data[31:0], 32'h0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
